// File: rtl/cal_bus_arb_pkg.sv
// Shared types and constants for the calibration bus arbiter.
// The command struct is sized for the widest supported bus; narrower buses zero-extend.
package cal_bus_arb_pkg;
    localparam int NUM_PORTS        = 2;
    localparam int MAX_READ_LATENCY = 8;
    localparam int CMD_ADDR_W       = 20;
    localparam int CMD_DATA_W       = 32;

    typedef logic port_id_t;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic                  lock;
        logic [CMD_ADDR_W-1:0] address;
        logic [CMD_DATA_W-1:0] write_data;
    } cmd_t;

    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction
endpackage

// File: rtl/cal_bus_rd_tag_pipe.sv
// Shift register carrying {valid, port} for each bus read so that the return
// can be steered back to the issuing master when the fixed-latency data arrives.
module cal_bus_rd_tag_pipe
    import cal_bus_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    input  port_id_t in_port,
    output logic     out_valid,
    output port_id_t out_port
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] prt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            prt <= '0;
        end else begin
            vld[0] <= in_valid;
            prt[0] <= in_port;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                prt[i] <= prt[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_port  = prt[DEPTH-1];

endmodule

// File: rtl/cal_bus_arbiter.sv
// Two-master arbiter for the EMIF calibration Avalon bus: round-robin grant,
// per-port lock with idle timeout, and fixed-latency read return routing.
module cal_bus_arbiter
    import cal_bus_arb_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int LOCK_TIMEOUT = 256,
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 32
) (
    input  logic              cal_bus_clk,
    input  logic              cal_bus_reset,

    input  logic              p0_read,
    input  logic              p0_write,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_write_data,
    output logic              p0_waitrequest,
    output logic [DATA_W-1:0] p0_read_data,
    output logic              p0_read_data_valid,

    input  logic              p1_read,
    input  logic              p1_write,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_write_data,
    output logic              p1_waitrequest,
    output logic [DATA_W-1:0] p1_read_data,
    output logic              p1_read_data_valid,

    output logic              cal_bus_avl_read,
    output logic              cal_bus_avl_write,
    output logic [ADDR_W-1:0] cal_bus_avl_address,
    output logic [DATA_W-1:0] cal_bus_avl_write_data,
    input  logic [DATA_W-1:0] cal_bus_avl_read_data,

    output logic [1:0]        lock_owner,
    output logic              err_lock_timeout,
    output logic              err_protocol,
    input  logic              err_clear
);

    localparam int TO_W = 16;
    localparam int RL   = (READ_LATENCY < 1) ? 1 :
                          (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

    cmd_t                 cmd0;
    cmd_t                 cmd1;
    cmd_t                 gcmd;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] gnt;
    logic                 gnt_any;
    port_id_t             gnt_port;

    port_id_t             favour;
    port_id_t             bus_port;
    logic                 owner_valid;
    port_id_t             owner_id;
    logic [TO_W-1:0]      idle_cnt;
    logic                 to_hit;
    logic                 proto_hit;

    logic                 tag_valid;
    port_id_t             tag_port;

    always_comb begin
        cmd0            = '0;
        cmd0.read       = p0_read;
        cmd0.write      = p0_write;
        cmd0.lock       = p0_lock;
        cmd0.address    = CMD_ADDR_W'(p0_address);
        cmd0.write_data = CMD_DATA_W'(p0_write_data);

        cmd1            = '0;
        cmd1.read       = p1_read;
        cmd1.write      = p1_write;
        cmd1.lock       = p1_lock;
        cmd1.address    = CMD_ADDR_W'(p1_address);
        cmd1.write_data = CMD_DATA_W'(p1_write_data);
    end

    // Reset gates eligibility so both masters see waitrequest while it is held.
    always_comb begin
        req[0]  = p0_read | p0_write;
        req[1]  = p1_read | p1_write;
        elig[0] = req[0] & (~owner_valid | (owner_id == 1'b0)) & ~cal_bus_reset;
        elig[1] = req[1] & (~owner_valid | (owner_id == 1'b1)) & ~cal_bus_reset;
        gnt[0]  = elig[0] & (~elig[1] | (favour == 1'b0));
        gnt[1]  = elig[1] & (~elig[0] | (favour == 1'b1));
        gnt_any  = |gnt;
        gnt_port = gnt[1];
        gcmd     = gnt[1] ? cmd1 : cmd0;
    end

    assign p0_waitrequest = ~gnt[0];
    assign p1_waitrequest = ~gnt[1];

    // With the lock held only the owner can be granted, so any grant is an owner command.
    assign to_hit    = owner_valid & ~gnt_any & (idle_cnt == TO_W'(LOCK_TIMEOUT - 1));
    assign proto_hit = (p0_read & p0_write) | (p1_read & p1_write);

    always_ff @(posedge cal_bus_clk or posedge cal_bus_reset) begin
        if (cal_bus_reset) begin
            cal_bus_avl_read       <= 1'b0;
            cal_bus_avl_write      <= 1'b0;
            cal_bus_avl_address    <= '0;
            cal_bus_avl_write_data <= '0;
            bus_port               <= 1'b0;
            favour                 <= 1'b0;
        end else begin
            cal_bus_avl_read  <= gnt_any & gcmd.read & ~gcmd.write;
            cal_bus_avl_write <= gnt_any & gcmd.write;
            if (gnt_any) begin
                cal_bus_avl_address    <= gcmd.address[ADDR_W-1:0];
                cal_bus_avl_write_data <= gcmd.write_data[DATA_W-1:0];
                bus_port               <= gnt_port;
            end
            if (to_hit) begin
                favour <= other_port(owner_id);
            end else if (gnt_any) begin
                favour <= other_port(gnt_port);
            end
        end
    end

    always_ff @(posedge cal_bus_clk or posedge cal_bus_reset) begin
        if (cal_bus_reset) begin
            owner_valid <= 1'b0;
            owner_id    <= 1'b0;
            idle_cnt    <= '0;
        end else if (!owner_valid) begin
            idle_cnt <= '0;
            if (gnt_any && gcmd.lock) begin
                owner_valid <= 1'b1;
                owner_id    <= gnt_port;
            end
        end else if (gnt_any) begin
            idle_cnt <= '0;
            if (!gcmd.lock) begin
                owner_valid <= 1'b0;
                owner_id    <= 1'b0;
            end
        end else if (to_hit) begin
            owner_valid <= 1'b0;
            owner_id    <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign lock_owner = {owner_valid, owner_id};

    // A new error in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge cal_bus_clk or posedge cal_bus_reset) begin
        if (cal_bus_reset) begin
            err_lock_timeout <= 1'b0;
            err_protocol     <= 1'b0;
        end else begin
            err_lock_timeout <= to_hit | (err_lock_timeout & ~err_clear);
            err_protocol     <= proto_hit | (err_protocol & ~err_clear);
        end
    end

    cal_bus_rd_tag_pipe #(
        .DEPTH (RL)
    ) u_tag_pipe (
        .clk       (cal_bus_clk),
        .rst       (cal_bus_reset),
        .in_valid  (cal_bus_avl_read),
        .in_port   (bus_port),
        .out_valid (tag_valid),
        .out_port  (tag_port)
    );

    always_ff @(posedge cal_bus_clk or posedge cal_bus_reset) begin
        if (cal_bus_reset) begin
            p0_read_data       <= '0;
            p0_read_data_valid <= 1'b0;
            p1_read_data       <= '0;
            p1_read_data_valid <= 1'b0;
        end else begin
            p0_read_data_valid <= tag_valid & (tag_port == 1'b0);
            p1_read_data_valid <= tag_valid & (tag_port == 1'b1);
            if (tag_valid && tag_port == 1'b0) begin
                p0_read_data <= cal_bus_avl_read_data;
            end
            if (tag_valid && tag_port == 1'b1) begin
                p1_read_data <= cal_bus_avl_read_data;
            end
        end
    end

endmodule

// File: tb/tb_cal_bus_arbiter.sv
// Directed bench for cal_bus_arbiter: read return, round-robin, lock, timeout,
// protocol error and reset-during-read, with hand-computed expectations.
module tb_cal_bus_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_read, p0_write, p0_lock;
    logic [AW-1:0] p0_address;
    logic [DW-1:0] p0_write_data;
    logic          p0_waitrequest;
    logic [DW-1:0] p0_read_data;
    logic          p0_read_data_valid;
    logic          p1_read, p1_write, p1_lock;
    logic [AW-1:0] p1_address;
    logic [DW-1:0] p1_write_data;
    logic          p1_waitrequest;
    logic [DW-1:0] p1_read_data;
    logic          p1_read_data_valid;
    logic          avl_read, avl_write;
    logic [AW-1:0] avl_address;
    logic [DW-1:0] avl_write_data;
    logic [DW-1:0] avl_read_data;
    logic [1:0]    lock_owner;
    logic          err_lock_timeout, err_protocol, err_clear;

    int n_chk = 0;
    int n_err = 0;
    int acc0, acc1;

    cal_bus_arbiter #(
        .READ_LATENCY (2),
        .LOCK_TIMEOUT (4),
        .ADDR_W       (AW),
        .DATA_W       (DW)
    ) dut (
        .cal_bus_clk            (clk),
        .cal_bus_reset          (rst),
        .p0_read                (p0_read),
        .p0_write               (p0_write),
        .p0_lock                (p0_lock),
        .p0_address             (p0_address),
        .p0_write_data          (p0_write_data),
        .p0_waitrequest         (p0_waitrequest),
        .p0_read_data           (p0_read_data),
        .p0_read_data_valid     (p0_read_data_valid),
        .p1_read                (p1_read),
        .p1_write               (p1_write),
        .p1_lock                (p1_lock),
        .p1_address             (p1_address),
        .p1_write_data          (p1_write_data),
        .p1_waitrequest         (p1_waitrequest),
        .p1_read_data           (p1_read_data),
        .p1_read_data_valid     (p1_read_data_valid),
        .cal_bus_avl_read       (avl_read),
        .cal_bus_avl_write      (avl_write),
        .cal_bus_avl_address    (avl_address),
        .cal_bus_avl_write_data (avl_write_data),
        .cal_bus_avl_read_data  (avl_read_data),
        .lock_owner             (lock_owner),
        .err_lock_timeout       (err_lock_timeout),
        .err_protocol           (err_protocol),
        .err_clear              (err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        p0_read = 0; p0_write = 0; p0_lock = 0; p0_address = '0; p0_write_data = '0;
        p1_read = 0; p1_write = 0; p1_lock = 0; p1_address = '0; p1_write_data = '0;
        avl_read_data = '0; err_clear = 0;
    endtask

    // Cycle starts 1 time unit after the rising edge; checks happen mid-cycle.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wait0"}, p0_waitrequest, 1);
        chk({tag, "_wait1"}, p1_waitrequest, 1);
        chk({tag, "_strobes"}, {avl_read, avl_write}, 0);
        chk({tag, "_addr"}, avl_address, 0);
        chk({tag, "_wdata"}, avl_write_data, 0);
        chk({tag, "_valids"}, {p0_read_data_valid, p1_read_data_valid}, 0);
        chk({tag, "_rdata"}, {p0_read_data, p1_read_data}, 0);
        chk({tag, "_lock"}, lock_owner, 0);
        chk({tag, "_errs"}, {err_lock_timeout, err_protocol}, 0);
    endtask

    function automatic logic [AW-1:0] rr_addr(input int j);
        return (j % 2 == 0) ? AW'(20'h100 + j / 2) : AW'(20'h200 + j / 2);
    endfunction

    initial begin
        idle_inputs();
        p0_read = 1;                 // request while reset is held must stay blocked
        #3;
        chk_reset_outputs("rst0");

        // Single read from port 0
        do_reset();
        p0_read = 1; p0_address = 20'h0_0040;
        settle();
        chk("rd_wait0", p0_waitrequest, 0);
        chk("rd_wait1", p1_waitrequest, 1);
        nxt(); p0_read = 0;
        settle();
        chk("rd_bus_rd", avl_read, 1);
        chk("rd_bus_addr", avl_address, 20'h0_0040);
        nxt(); settle();
        chk("rd_bus_rd_c2", avl_read, 0);
        nxt(); avl_read_data = 32'hDEADBEEF;
        settle();
        chk("rd_valid_c3", p0_read_data_valid, 0);
        nxt(); settle();
        chk("rd_valid_c4", p0_read_data_valid, 1);
        chk("rd_data_c4", p0_read_data, 32'hDEADBEEF);
        chk("rd_p1_valid_c4", p1_read_data_valid, 0);
        nxt(); settle();
        chk("rd_valid_c5", {p0_read_data_valid, p1_read_data_valid}, 0);

        // Both ports write continuously: strict alternation
        do_reset();
        acc0 = 0; acc1 = 0;
        for (int k = 0; k < 6; k++) begin
            p0_write = 1; p1_write = 1;
            p0_address    = AW'(20'h100 + (k + 1) / 2);
            p0_write_data = 32'hA500_0100 + 32'((k + 1) / 2);
            p1_address    = AW'(20'h200 + k / 2);
            p1_write_data = 32'hA500_0200 + 32'(k / 2);
            settle();
            chk("rr_wait0", p0_waitrequest, (k % 2) != 0);
            chk("rr_wait1", p1_waitrequest, (k % 2) == 0);
            if (!p0_waitrequest) acc0++;
            if (!p1_waitrequest) acc1++;
            if (k > 0) begin
                chk("rr_bus_wr", avl_write, 1);
                chk("rr_bus_addr", avl_address, rr_addr(k - 1));
                chk("rr_bus_wdata", avl_write_data, {12'hA50, rr_addr(k - 1)});
            end
            nxt();
        end
        idle_inputs();
        settle();
        chk("rr_bus_wr_last", avl_write, 1);
        chk("rr_bus_addr_last", avl_address, rr_addr(5));
        chk("rr_acc0", acc0, 3);
        chk("rr_acc1", acc1, 3);
        nxt(); settle();
        chk("rr_bus_wr_end", avl_write, 0);

        // Port 1 locked read then unlocking write, port 0 waiting
        do_reset();
        p1_read = 1; p1_lock = 1; p1_address = 20'h777;
        settle();
        chk("lk_wait1_c0", p1_waitrequest, 0);
        nxt();
        p1_read = 0; p1_lock = 0;
        p0_write = 1; p0_address = 20'h0AA; p0_write_data = 32'h11;
        settle();
        chk("lk_owner_c1", lock_owner, 2'b11);
        chk("lk_wait0_c1", p0_waitrequest, 1);
        nxt();
        p1_write = 1; p1_address = 20'h778; p1_write_data = 32'h22;
        settle();
        chk("lk_wait1_c2", p1_waitrequest, 0);
        chk("lk_wait0_c2", p0_waitrequest, 1);
        chk("lk_owner_c2", lock_owner, 2'b11);
        nxt();
        p1_write = 0; avl_read_data = 32'h12345678;
        settle();
        chk("lk_owner_c3", lock_owner, 2'b00);
        chk("lk_wait0_c3", p0_waitrequest, 0);
        chk("lk_bus_addr_c3", {avl_write, avl_address}, {1'b1, 20'h778});
        nxt();
        p0_write = 0;
        settle();
        chk("lk_p1_valid", p1_read_data_valid, 1);
        chk("lk_p1_data", p1_read_data, 32'h12345678);
        chk("lk_p0_hold", {p0_read_data_valid, p0_read_data}, 0);
        chk("lk_bus_addr_c4", {avl_write, avl_address}, {1'b1, 20'h0AA});

        // Lock timeout with LOCK_TIMEOUT = 4
        do_reset();
        p0_read = 1; p0_lock = 1; p0_address = 20'h5;
        settle();
        chk("to_wait0_c0", p0_waitrequest, 0);
        nxt();
        p0_read = 0; p0_lock = 0;
        p1_read = 1; p1_address = 20'h9;
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk("to_owner_held", lock_owner, 2'b10);
            chk("to_wait1_held", p1_waitrequest, 1);
            chk("to_err_early", err_lock_timeout, 0);
            nxt();
        end
        settle();
        chk("to_owner_free", lock_owner, 2'b00);
        chk("to_err_set", err_lock_timeout, 1);
        chk("to_wait1_c5", p1_waitrequest, 0);
        nxt();
        p1_read = 0; err_clear = 1;
        settle();
        chk("to_err_c6", err_lock_timeout, 1);
        nxt();
        err_clear = 0;
        settle();
        chk("to_err_cleared", err_lock_timeout, 0);

        // Protocol error: read and write together on port 1
        do_reset();
        p1_read = 1; p1_write = 1; p1_address = 20'h333; p1_write_data = 32'h55AA55AA;
        settle();
        chk("pe_wait1", p1_waitrequest, 0);
        nxt();
        idle_inputs();
        settle();
        chk("pe_bus_strobes", {avl_read, avl_write}, 2'b01);
        chk("pe_bus_addr", avl_address, 20'h333);
        chk("pe_bus_wdata", avl_write_data, 32'h55AA55AA);
        chk("pe_err", err_protocol, 1);
        for (int k = 2; k <= 5; k++) begin
            nxt(); settle();
            chk("pe_no_return", p1_read_data_valid, 0);
        end
        nxt();
        err_clear = 1; p0_read = 1; p0_write = 1;
        settle();
        nxt();
        err_clear = 0; p0_read = 0; p0_write = 0;
        settle();
        chk("pe_set_wins", err_protocol, 1);
        nxt();
        err_clear = 1;
        settle();
        nxt();
        err_clear = 0;
        settle();
        chk("pe_cleared", err_protocol, 0);

        // Reset with two reads in flight
        do_reset();
        p0_read = 1; p0_address = 20'h1;
        settle();
        chk("rr2_wait0", p0_waitrequest, 0);
        nxt();
        p0_read = 0; p1_read = 1; p1_address = 20'h2;
        settle();
        chk("rr2_wait1", p1_waitrequest, 0);
        chk("rr2_bus_rd0", avl_read, 1);
        nxt();
        p1_read = 0;
        settle();
        chk("rr2_bus_rd1", {avl_read, avl_address}, {1'b1, 20'h2});
        nxt();
        rst = 1; p0_read = 1; avl_read_data = 32'hCAFE0001;
        settle();
        chk_reset_outputs("rr2_rst_c3");
        nxt();
        avl_read_data = 32'hCAFE0002;
        settle();
        chk_reset_outputs("rr2_rst_c4");
        nxt();
        rst = 0; p0_read = 0;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("rr2_no_valid", {p0_read_data_valid, p1_read_data_valid}, 0);
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cal_bus_arbiter.md
Name: cal_bus_arbiter

Overview:
- Shares the 20-bit/32-bit EMIF calibration Avalon bus between two masters: port 0 (sequencer-side debug/toolkit path) and port 1 (core-logic test master).
- Sits between the masters and the cal bus slave in the EMIF arch wrapper.
- Issues at most one command per cycle and routes fixed-latency read returns back to the issuing port.
- Supports a per-port lock for atomic read-modify-write, with a lock timeout.

Parameters:
- READ_LATENCY, 2, cycles from bus read assertion to valid cal_bus_avl_read_data (legal 1..8).
- LOCK_TIMEOUT, 256, idle cycles a locked owner may hold the bus before forced release (legal 2..65535).
- ADDR_W, 20, address width; DATA_W, 32, data width.

Ports:
- cal_bus_clk  in  1  single clock for all logic
- cal_bus_reset  in  1  asynchronous, active-high reset
- pN_read, pN_write  in  1 each  command strobes, N=0,1
- pN_lock  in  1  request/keep ownership after this command
- pN_address  in  ADDR_W  word address
- pN_write_data  in  DATA_W  write data
- pN_waitrequest  out  1  command not accepted this cycle
- pN_read_data  out  DATA_W  returned read data
- pN_read_data_valid  out  1  one-cycle return strobe
- cal_bus_avl_read, cal_bus_avl_write  out  1 each  bus strobes (registered)
- cal_bus_avl_address  out  ADDR_W  registered bus address
- cal_bus_avl_write_data  out  DATA_W  registered bus write data
- cal_bus_avl_read_data  in  DATA_W  bus read data, valid READ_LATENCY cycles after read
- lock_owner  out  2  {valid, port id} of current lock holder
- err_lock_timeout  out  1  sticky: forced lock release occurred
- err_protocol  out  1  sticky: read and write asserted together on a port
- err_clear  in  1  clears both sticky error flags

Behaviour:
- Reset:
  - All outputs 0, except pN_waitrequest=1.
  - Round-robin pointer = port 0 favoured.
  - Lock free, timeout counter 0, return tag pipe cleared.
  - Asserting reset mid-read drops the read: no read_data_valid is produced for it after reset releases.
- Arbitration (combinational from current registered state):
  - Requesting = read|write.
  - If locked, only the owner is eligible.
  - Otherwise, if both ports request, the one not granted last wins; if one requests, it wins.
  - Winner sees waitrequest=0 this cycle; the loser sees waitrequest=1.
  - Non-requesting ports see waitrequest=1.
  - Pointer updates only on an actual grant.
- Command issue:
  - The granted command is registered onto cal_bus_avl_* on the next edge, so bus strobes lag acceptance by 1 cycle.
  - Bus strobes are high for exactly one cycle per accepted command.
  - Back-to-back grants on consecutive cycles are legal (throughput 1/cycle).
- Read return:
  - A READ_LATENCY-deep tag shift register records {valid, port} aligned with bus reads.
  - When the tag emerges, cal_bus_avl_read_data is registered into pN_read_data with pN_read_data_valid for one cycle.
  - Total latency from accept edge to valid = READ_LATENCY+2 cycles.
  - Returns keep issue order.
  - The non-target port's read_data holds its previous value.
- Lock:
  - An accepted command with pN_lock=1 and the lock free makes N the owner (lock_owner={1,N}) from the next cycle.
  - An owner command with lock=0 releases the lock after acceptance; the other port becomes eligible the next cycle.
  - The timeout counter increments each cycle the owner issues no command and resets on every owner command.
  - When it reaches LOCK_TIMEOUT: release the lock, set err_lock_timeout, and flip the pointer to the other port.
  - A locked port's requests are never blocked by the other port.
- Protocol error:
  - read&write together: the write is taken, the read is ignored, err_protocol is set.
  - If err_clear coincides with a new error, the set wins.

Decomposition:
- Package cal_bus_arb_pkg holds:
  - typedef port_id_t (1 bit);
  - struct cmd_t {read, write, lock, address, write_data};
  - constants NUM_PORTS=2 and MAX_READ_LATENCY=8.
- One sub-module, cal_bus_rd_tag_pipe: the parameterized READ_LATENCY shift register carrying the {valid, port} tag, with asynchronous clear.
- Arbitration, lock and error logic stay in the top.

Test Plan:
- Single read port 0, addr 20'h0_0040, READ_LATENCY=2:
  - bus read at cycle 1 with addr 0x00040;
  - bus returns 0xDEADBEEF at cycle 3;
  - p0_read_data_valid with data 0xDEADBEEF at cycle 4;
  - p1 never gets valid.
- Both ports write continuously for 6 cycles:
  - grants alternate 0,1,0,1,0,1;
  - each port accepts 3 writes;
  - bus write strobe high 6 consecutive cycles.
- Port 1 locked read then write (lock=1, then lock=0) while port 0 requests throughout:
  - port 0 waitrequest=1 until the cycle after port 1's unlocking write is accepted;
  - port 0 is accepted next.
- Port 0 locks, then stays idle with LOCK_TIMEOUT=4:
  - lock_owner cleared after 4 idle cycles;
  - err_lock_timeout=1;
  - pending port 1 read accepted the following cycle;
  - err_clear drops the flag.
- Port 1 asserts read and write together:
  - bus write issued, no read tag, err_protocol=1.
- Two reads in flight (p0 then p1), cal_bus_reset asserted 1 cycle after the second bus read:
  - no read_data_valid on either port after reset;
  - all outputs at reset values while reset is high.
